sao_stat_ctrl: RTL and testbench

SAO_STAT_CTRL -- requirements
Module: sao_stat_ctrl

---
 rtl/sao_pkg.sv | 25 ++
 rtl/sao_stat_ctrl_if.sv | 23 ++
 rtl/sao_stat_acc.sv | 59 +++++
 rtl/sao_stat_ctrl.sv | 142 ++++++++++++++
 tb/tb_sao_stat_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sao_pkg.sv
// Shared types and width helpers for the SAO edge-offset statistics controller.
package sao_pkg;

    localparam int NUM_CAT = 4;
    localparam int NUM_W   = 13;

    function automatic int sao_sw(input int diff_clip_bit);
        return diff_clip_bit + 5;
    endfunction

    typedef enum logic [1:0] {
        EO_VALLEY,
        EO_CONCAVE,
        EO_CONVEX,
        EO_PEAK
    } eo_cat_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } sao_state_e;

endpackage

// File: rtl/sao_stat_ctrl_if.sv
// Block request / result bus between the controller and the one-block statistics datapath.
interface sao_stat_ctrl_if #(
    parameter int SW = 9
);
    logic                 blk_req;
    logic                 blk_ack;
    logic [3:0]           blk_x;
    logic [3:0]           blk_y;
    logic                 res_vld;
    logic [1:0]           res_cat;
    logic signed [SW-1:0] res_sum;
    logic [4:0]           res_num;

    modport master (
        output blk_req, blk_x, blk_y,
        input  blk_ack, res_vld, res_cat, res_sum, res_num
    );

    modport slave (
        input  blk_req, blk_x, blk_y,
        output blk_ack, res_vld, res_cat, res_sum, res_num
    );
endinterface

// File: rtl/sao_stat_acc.sv
// Four-entry per-category accumulator bank: clear wins over add.
module sao_stat_acc
    import sao_pkg::*;
#(
    parameter int SW = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 add,
    input  eo_cat_e              cat,
    input  logic signed [SW-1:0] sum,
    input  logic [4:0]           num,
    output logic signed [SW+7:0] acc_sum [NUM_CAT],
    output logic [NUM_W-1:0]     acc_num [NUM_CAT]
);

    logic signed [SW+7:0] sum_q [NUM_CAT];
    logic signed [SW+7:0] sum_d [NUM_CAT];
    logic [NUM_W-1:0]     num_q [NUM_CAT];
    logic [NUM_W-1:0]     num_d [NUM_CAT];
    logic signed [SW+7:0] sum_ext;
    logic [NUM_W-1:0]     num_ext;

    assign sum_ext = (SW+8)'(sum);
    assign num_ext = NUM_W'(num);

    always_comb begin
        for (int i = 0; i < NUM_CAT; i++) begin
            sum_d[i] = sum_q[i];
            num_d[i] = num_q[i];
            if (clr) begin
                sum_d[i] = '0;
                num_d[i] = '0;
            end else if (add && (cat == eo_cat_e'(i))) begin
                sum_d[i] = sum_q[i] + sum_ext;
                num_d[i] = num_q[i] + num_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAT; i++) begin
                sum_q[i] <= '0;
                num_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CAT; i++) begin
                sum_q[i] <= sum_d[i];
                num_q[i] <= num_d[i];
            end
        end
    end

    assign acc_sum = sum_q;
    assign acc_num = num_q;

endmodule

// File: rtl/sao_stat_ctrl.sv
// Walks the 4x4 blocks of one CTB in raster order, one block outstanding at a time,
// and accumulates per-EO-category diff sums and sample counts.
module sao_stat_ctrl
    import sao_pkg::*;
#(
    parameter int  diff_clip_bit = 4,
    parameter int  max_log2_ctb  = 6,
    localparam int SW            = sao_sw(diff_clip_bit)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            log2_ctb,
    output logic                  busy,
    sao_stat_ctrl_if.master       bif,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic signed [SW+7:0]  acc_sum [NUM_CAT],
    output logic [NUM_W-1:0]      acc_num [NUM_CAT],
    output logic                  err
);

    sao_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic       blk_req_q, blk_req_d;
    logic       out_vld_q, out_vld_d;
    logic       err_q, err_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [3:0] max_q, max_d;
    logic       acc_clr, acc_add;
    logic       l2_ok;
    logic [3:0] blk_max;

    assign l2_ok   = (log2_ctb >= 3'd4) && (int'(log2_ctb) <= max_log2_ctb);
    assign blk_max = l2_ok ? 4'((1 << (int'(log2_ctb) - 2)) - 1) : 4'd3;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        blk_req_d = blk_req_q;
        out_vld_d = out_vld_q;
        err_d     = err_q;
        x_d       = x_q;
        y_d       = y_q;
        max_d     = max_q;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    max_d   = blk_max;
                    err_d   = !l2_ok;
                    acc_clr = 1'b1;
                end
            end
            // First ISSUE cycle only raises blk_req, so indices are settled a cycle before the request.
            ISSUE: begin
                if (blk_req_q && bif.blk_ack) begin
                    blk_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    blk_req_d = 1'b1;
                end
            end
            WAIT: begin
                if (bif.res_vld) begin
                    acc_add = 1'b1;
                    state_d = ISSUE;
                    if (x_q == max_q) begin
                        x_d = '0;
                        if (y_q == max_q) begin
                            y_d       = '0;
                            state_d   = OUT;
                            out_vld_d = 1'b1;
                        end else begin
                            y_d = y_q + 4'd1;
                        end
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end
            end
            OUT: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A stray result outside WAIT is flagged even when it coincides with a start.
        if (bif.res_vld && (state_q != WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            blk_req_q <= 1'b0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            max_q     <= 4'd3;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            blk_req_q <= blk_req_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            max_q     <= max_d;
        end
    end

    sao_stat_acc #(.SW(SW)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .add     (acc_add),
        .cat     (eo_cat_e'(bif.res_cat)),
        .sum     (bif.res_sum),
        .num     (bif.res_num),
        .acc_sum (acc_sum),
        .acc_num (acc_num)
    );

    assign busy        = busy_q;
    assign out_vld     = out_vld_q;
    assign err         = err_q;
    assign bif.blk_req = blk_req_q;
    assign bif.blk_x   = x_q;
    assign bif.blk_y   = y_q;

endmodule

// File: tb/tb_sao_stat_ctrl.sv
// Directed bench for sao_stat_ctrl: raster order, loop timing, accumulation, handshakes, errors, reset.
module tb_sao_stat_ctrl;

    localparam int SW = 9;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [2:0]           log2_ctb = 3'd4;
    logic                 busy;
    logic                 out_vld;
    logic                 out_rdy = 1'b0;
    logic                 err;
    logic signed [SW+7:0] acc_sum [4];
    logic [12:0]          acc_num [4];

    logic signed [SW+7:0] exp_sum [4];
    logic [12:0]          exp_num [4];

    int checks = 0;
    int errors = 0;

    sao_stat_ctrl_if #(.SW(SW)) bif ();

    sao_stat_ctrl #(.diff_clip_bit(4), .max_log2_ctb(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .log2_ctb (log2_ctb),
        .busy     (busy),
        .bif      (bif.master),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .acc_sum  (acc_sum),
        .acc_num  (acc_num),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_all_zero(input string name);
        checks++;
        if (busy !== 1'b0 || bif.blk_req !== 1'b0 || out_vld !== 1'b0 || err !== 1'b0 ||
            bif.blk_x !== 4'd0 || bif.blk_y !== 4'd0) begin
            errors++;
            $display("FAIL %s ctrl: busy=%b req=%b vld=%b err=%b x=%0d y=%0d, want all 0",
                     name, busy, bif.blk_req, out_vld, err, bif.blk_x, bif.blk_y);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_sum[i] !== '0 || acc_num[i] !== '0) begin
                errors++;
                $display("FAIL %s acc[%0d]: sum=%0d num=%0d, want 0 0", name, i, acc_sum[i], acc_num[i]);
            end
        end
    endtask

    task automatic check_acc(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_sum[i] !== exp_sum[i] || acc_num[i] !== exp_num[i]) begin
                errors++;
                $display("FAIL %s acc[%0d]: sum=%0d num=%0d, want %0d %0d",
                         name, i, acc_sum[i], acc_num[i], exp_sum[i], exp_num[i]);
            end
        end
    endtask

    // One CTB with a constant per-block result; abort_blk >= 0 resets during that block's WAIT.
    task automatic run_ctb(input string name, input logic [2:0] l2, input int ack_dly,
                           input logic [1:0] cat, input int sum, input int num,
                           input int rdy_dly, input int abort_blk, input bit start_in_out);
        int n, nblk, cnt, w;
        logic [3:0] ex, ey;
        bit legal;
        legal = (l2 >= 3'd4 && l2 <= 3'd6);
        n     = legal ? (1 << (int'(l2) - 2)) : 4;
        nblk  = n * n;
        @(negedge clk);
        start = 1'b1; log2_ctb = l2;
        @(negedge clk);
        start = 1'b0; log2_ctb = 3'd0; cnt = 0;
        checks++;
        if (busy !== 1'b1 || err !== !legal) begin
            errors++;
            $display("FAIL %s start: busy=%b err=%b, want 1 %b", name, busy, err, !legal);
        end
        for (int b = 0; b < nblk; b++) begin
            w = 0;
            while (bif.blk_req !== 1'b1 && w < 20) begin
                @(negedge clk); cnt++; w++;
            end
            checks++;
            if (w >= 20) begin
                errors++;
                $display("FAIL %s req_timeout blk %0d: no blk_req, want blk_req=1", name, b);
                return;
            end
            ex = 4'(b % n); ey = 4'(b / n);
            checks++;
            if (bif.blk_x !== ex || bif.blk_y !== ey) begin
                errors++;
                $display("FAIL %s order blk %0d: x=%0d y=%0d, want %0d %0d", name, b, bif.blk_x, bif.blk_y, ex, ey);
            end
            for (int d = 0; d < ack_dly; d++) begin
                if (b == 0 && d == 0) begin start = 1'b1; log2_ctb = 3'd7; end
                @(negedge clk); cnt++;
                start = 1'b0;
                checks++;
                if (bif.blk_req !== 1'b1 || bif.blk_x !== ex || bif.blk_y !== ey || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold blk %0d: req=%b x=%0d y=%0d err=%b, want 1 %0d %0d 0",
                             name, b, bif.blk_req, bif.blk_x, bif.blk_y, err, ex, ey);
                end
            end
            bif.blk_ack = 1'b1;
            @(negedge clk); cnt++;
            bif.blk_ack = 1'b0;
            checks++;
            if (bif.blk_req !== 1'b0) begin
                errors++;
                $display("FAIL %s req_drop blk %0d: req=%b, want 0", name, b, bif.blk_req);
            end
            if (b == abort_blk) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({name, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin exp_sum[i] = '0; exp_num[i] = '0; end
                return;
            end
            bif.res_vld = 1'b1; bif.res_cat = cat; bif.res_sum = SW'(sum); bif.res_num = 5'(num);
            @(negedge clk); cnt++;
            bif.res_vld = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            exp_sum[i] = (i == int'(cat)) ? (SW+8)'(nblk * sum) : '0;
            exp_num[i] = (i == int'(cat)) ? 13'(nblk * num) : '0;
        end
        checks++;
        if (out_vld !== 1'b1 || (ack_dly == 0 && cnt != 3 * nblk)) begin
            errors++;
            $display("FAIL %s out_vld: vld=%b at cycle %0d, want 1 at %0d", name, out_vld, cnt, 3 * nblk);
        end
        check_acc(name);
        for (int r = 0; r < rdy_dly; r++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || busy !== 1'b1 || acc_sum[cat] !== exp_sum[cat] || acc_num[cat] !== exp_num[cat]) begin
                errors++;
                $display("FAIL %s out_hold %0d: vld=%b busy=%b sum=%0d num=%0d, want 1 1 %0d %0d",
                         name, r, out_vld, busy, acc_sum[cat], acc_num[cat], exp_sum[cat], exp_num[cat]);
            end
        end
        out_rdy = 1'b1; start = start_in_out; log2_ctb = 3'd4;
        @(negedge clk);
        out_rdy = 1'b0; start = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s out_done: vld=%b busy=%b, want 0 0", name, out_vld, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ctb16();
        run_ctb("ctb16", 3'd4, 0, 2'd1, 3, 16, 0, -1, 1'b0);
        checks++;
        if (acc_sum[1] !== 17'sd48 || acc_num[1] !== 13'd256) begin
            errors++;
            $display("FAIL ctb16_const: sum=%0d num=%0d, want 48 256", acc_sum[1], acc_num[1]);
        end
    endtask

    task automatic test_ctb64();
        logic signed [SW+7:0] want;
        want = -32768;
        run_ctb("ctb64", 3'd6, 0, 2'd0, -128, 16, 0, -1, 1'b0);
        checks++;
        if (acc_sum[0] !== want || acc_num[0] !== 13'd4096) begin
            errors++;
            $display("FAIL ctb64_const: sum=%0d num=%0d, want -32768 4096", acc_sum[0], acc_num[0]);
        end
    endtask

    task automatic test_back_pressure();
        logic signed [SW+7:0] want;
        want = -112;
        run_ctb("bp", 3'd4, 5, 2'd2, -7, 9, 10, -1, 1'b0);
        checks++;
        if (acc_sum[2] !== want || acc_num[2] !== 13'd144) begin
            errors++;
            $display("FAIL bp_const: sum=%0d num=%0d, want -112 144", acc_sum[2], acc_num[2]);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        bif.res_vld = 1'b1; bif.res_cat = 2'd3; bif.res_sum = SW'(50); bif.res_num = 5'd4;
        @(negedge clk);
        bif.res_vld = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL spurious_err: err=%b, want 1", err);
        end
        check_acc("spurious_hold");
        run_ctb("after_spur", 3'd4, 0, 2'd3, 1, 1, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_ctb("mid_rst", 3'd5, 0, 2'd0, 10, 16, 0, 7, 1'b0);
        run_ctb("post_rst", 3'd5, 0, 2'd3, 1, 2, 0, -1, 1'b1);
        checks++;
        if (acc_sum[3] !== 17'sd64 || acc_num[3] !== 13'd128) begin
            errors++;
            $display("FAIL post_rst_const: sum=%0d num=%0d, want 64 128", acc_sum[3], acc_num[3]);
        end
    endtask

    task automatic test_illegal();
        run_ctb("illegal", 3'd7, 0, 2'd2, 5, 16, 0, -1, 1'b0);
        checks++;
        if (err !== 1'b1 || acc_sum[2] !== 17'sd80 || acc_num[2] !== 13'd256) begin
            errors++;
            $display("FAIL illegal_const: err=%b sum=%0d num=%0d, want 1 80 256", err, acc_sum[2], acc_num[2]);
        end
    endtask

    initial begin
        bif.blk_ack = 1'b0;
        bif.res_vld = 1'b0;
        bif.res_cat = 2'd0;
        bif.res_sum = '0;
        bif.res_num = 5'd0;
        for (int i = 0; i < 4; i++) begin exp_sum[i] = '0; exp_num[i] = '0; end
        test_reset();
        test_ctb16();
        test_ctb64();
        test_back_pressure();
        test_spurious();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
